// File: rtl/power_seq_ctrl.sv
// Power-domain sequencer: orders isolation, retention and the power switch
// on the way down and back up, with an ack timeout and a sticky error flag.
module power_seq_ctrl #(
    parameter int DLY_W   = 8,
    parameter int ISO_DLY = 4,
    parameter int RET_DLY = 4,
    parameter int TMO     = 16
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       p_flag,
    input  logic       pse_ack,
    input  logic       err_clr,
    output logic       iso_en,
    output logic       ret_en,
    output logic       pse,
    output logic       busy,
    output logic       dom_off,
    output logic       err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_ON        = 3'd0,
        ST_ISO_W     = 3'd1,
        ST_RET_W     = 3'd2,
        ST_PSW_OFF_W = 3'd3,
        ST_OFF       = 3'd4,
        ST_PSW_ON_W  = 3'd5,
        ST_RST_W     = 3'd6
    } state_t;

    localparam logic [DLY_W-1:0] ISO_LAST = DLY_W'(ISO_DLY - 1);
    localparam logic [DLY_W-1:0] RET_LAST = DLY_W'(RET_DLY - 1);
    localparam logic [DLY_W-1:0] TMO_LAST = DLY_W'(TMO - 1);

    state_t           cur;
    state_t           nxt;
    logic [DLY_W-1:0] cnt;
    logic [DLY_W-1:0] cnt_nxt;
    logic             tmo_hit;
    logic             iso_d;
    logic             ret_d;
    logic             pse_d;
    logic             busy_d;
    logic             off_d;

    assign state = cur;

    always_comb begin
        nxt     = cur;
        tmo_hit = 1'b0;
        unique case (cur)
            ST_ON: begin
                if (p_flag) nxt = ST_ISO_W;
            end
            ST_ISO_W: begin
                if (cnt == ISO_LAST) nxt = ST_RET_W;
            end
            ST_RET_W: begin
                if (cnt == RET_LAST) nxt = ST_PSW_OFF_W;
            end
            ST_PSW_OFF_W: begin
                if (!pse_ack) begin
                    nxt = ST_OFF;
                end else if (cnt == TMO_LAST) begin
                    nxt     = ST_OFF;
                    tmo_hit = 1'b1;
                end
            end
            ST_OFF: begin
                if (!p_flag) nxt = ST_PSW_ON_W;
            end
            ST_PSW_ON_W: begin
                if (pse_ack) begin
                    nxt = ST_RST_W;
                end else if (cnt == TMO_LAST) begin
                    nxt     = ST_RST_W;
                    tmo_hit = 1'b1;
                end
            end
            ST_RST_W: begin
                if (cnt == ISO_LAST) nxt = ST_ON;
            end
            default: nxt = ST_ON;
        endcase
    end

    // Counter restarts on every state entry and idles at zero in ON/OFF
    always_comb begin
        cnt_nxt = cnt;
        if (nxt != cur || nxt == ST_ON || nxt == ST_OFF) begin
            cnt_nxt = '0;
        end else if (cnt != '1) begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    always_comb begin
        iso_d  = 1'b1;
        ret_d  = 1'b1;
        pse_d  = 1'b1;
        busy_d = 1'b1;
        off_d  = 1'b0;
        unique case (nxt)
            ST_ON: begin
                iso_d  = 1'b0;
                ret_d  = 1'b0;
                busy_d = 1'b0;
            end
            ST_ISO_W: begin
                ret_d = 1'b0;
            end
            ST_RET_W: begin
            end
            ST_PSW_OFF_W: begin
                pse_d = 1'b0;
            end
            ST_OFF: begin
                pse_d  = 1'b0;
                busy_d = 1'b0;
                off_d  = 1'b1;
            end
            ST_PSW_ON_W: begin
            end
            ST_RST_W: begin
                ret_d = 1'b0;
            end
            default: begin
                iso_d  = 1'b0;
                ret_d  = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            cur     <= ST_ON;
            cnt     <= '0;
            iso_en  <= 1'b0;
            ret_en  <= 1'b0;
            pse     <= 1'b1;
            busy    <= 1'b0;
            dom_off <= 1'b0;
            err     <= 1'b0;
        end else begin
            cur     <= nxt;
            cnt     <= cnt_nxt;
            iso_en  <= iso_d;
            ret_en  <= ret_d;
            pse     <= pse_d;
            busy    <= busy_d;
            dom_off <= off_d;
            // A timeout on the same edge as a clear leaves err set
            if (tmo_hit) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_power_seq_ctrl.sv
// Directed bench for power_seq_ctrl: sequencing timing, timeout, err
// handling, mid-sequence request changes and resets, plus ordering checks.
module tb_power_seq_ctrl;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic       p_flag;
    logic       pse_ack;
    logic       err_clr;
    logic       iso_en;
    logic       ret_en;
    logic       pse;
    logic       busy;
    logic       dom_off;
    logic       err;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    power_seq_ctrl dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .p_flag  (p_flag),
        .pse_ack (pse_ack),
        .err_clr (err_clr),
        .iso_en  (iso_en),
        .ret_en  (ret_en),
        .pse     (pse),
        .busy    (busy),
        .dom_off (dom_off),
        .err     (err),
        .state   (state)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Ordering invariants sampled mid-cycle
    always @(negedge CLK) begin
        if (mon_en) begin
            chk("inv_pse_off", 8'(pse | (ret_en & iso_en)), 8'd1);
            chk("inv_iso_off", 8'(iso_en | (~ret_en & pse)), 8'd1);
        end
    end

    initial begin
        // 1. reset with random inputs
        RSTn    = 1'b0;
        p_flag  = 1'($urandom);
        pse_ack = 1'($urandom);
        err_clr = 1'($urandom);
        step();
        p_flag  = 1'($urandom);
        pse_ack = 1'($urandom);
        err_clr = 1'($urandom);
        step();
        chk("rst_iso", 8'(iso_en), 8'd0);
        chk("rst_ret", 8'(ret_en), 8'd0);
        chk("rst_pse", 8'(pse), 8'd1);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_off", 8'(dom_off), 8'd0);
        chk("rst_err", 8'(err), 8'd0);
        chk("rst_state", 8'(state), 8'd0);
        RSTn    = 1'b1;
        p_flag  = 1'b0;
        pse_ack = 1'b1;
        err_clr = 1'b0;
        step();
        mon_en = 1'b1;
        chk("idle_state", 8'(state), 8'd0);

        // 2. power-down with ack dropping at edge 11
        p_flag = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            step();
            chk("dn_iso", 8'(iso_en), 8'(n >= 1));
            chk("dn_ret", 8'(ret_en), 8'(n >= 5));
            chk("dn_pse", 8'(pse), 8'(n < 9));
            chk("dn_off", 8'(dom_off), 8'(n >= 12));
            chk("dn_busy", 8'(busy), 8'(n < 12));
            if (n == 11) pse_ack = 1'b0;
        end
        chk("dn_state", 8'(state), 8'd4);
        chk("dn_err", 8'(err), 8'd0);

        // 3. power-up with ack rising at edge 3
        p_flag = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            step();
            chk("up_pse", 8'(pse), 8'd1);
            chk("up_ret", 8'(ret_en), 8'(n < 4));
            chk("up_iso", 8'(iso_en), 8'(n < 8));
            chk("up_busy", 8'(busy), 8'(n < 8));
            chk("up_off", 8'(dom_off), 8'd0);
            if (n == 3) pse_ack = 1'b1;
        end
        chk("up_state", 8'(state), 8'd0);

        // 4. power-down timeout with ack stuck high
        p_flag = 1'b1;
        for (int n = 1; n <= 25; n++) begin
            step();
            if (n == 24) begin
                chk("tmo_pre_state", 8'(state), 8'd3);
                chk("tmo_pre_err", 8'(err), 8'd0);
            end
        end
        chk("tmo_state", 8'(state), 8'd4);
        chk("tmo_err", 8'(err), 8'd1);
        chk("tmo_off", 8'(dom_off), 8'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_err", 8'(err), 8'd0);

        // power-up timeout colliding with err_clr: set wins
        pse_ack = 1'b0;
        p_flag  = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            step();
            if (n == 1) chk("pu_tmo_st5", 8'(state), 8'd5);
            if (n == 16) begin
                chk("pu_tmo_pre", 8'(err), 8'd0);
                err_clr = 1'b1;
            end
        end
        err_clr = 1'b0;
        chk("setwin_err", 8'(err), 8'd1);
        chk("setwin_state", 8'(state), 8'd6);
        pse_ack = 1'b1;
        for (int n = 18; n <= 21; n++) step();
        chk("pu_tmo_on", 8'(state), 8'd0);
        chk("pu_tmo_iso", 8'(iso_en), 8'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr2_err", 8'(err), 8'd0);

        // 5. single-cycle request runs the whole sequence
        p_flag = 1'b1;
        step();
        p_flag = 1'b0;
        chk("pulse_st1", 8'(state), 8'd1);
        for (int n = 2; n <= 16; n++) begin
            step();
            if (n == 9) begin
                chk("pulse_st3", 8'(state), 8'd3);
                pse_ack = 1'b0;
            end
            if (n == 10) begin
                chk("pulse_st4", 8'(state), 8'd4);
                chk("pulse_off", 8'(dom_off), 8'd1);
            end
            if (n == 11) begin
                chk("pulse_st5", 8'(state), 8'd5);
                chk("pulse_pse", 8'(pse), 8'd1);
                pse_ack = 1'b1;
            end
        end
        chk("pulse_on", 8'(state), 8'd0);
        chk("pulse_err", 8'(err), 8'd0);

        // 6. reset while in RET_W
        p_flag = 1'b1;
        for (int n = 1; n <= 6; n++) step();
        chk("mid_st2", 8'(state), 8'd2);
        RSTn = 1'b0;
        step();
        chk("mid_iso", 8'(iso_en), 8'd0);
        chk("mid_ret", 8'(ret_en), 8'd0);
        chk("mid_pse", 8'(pse), 8'd1);
        chk("mid_busy", 8'(busy), 8'd0);
        chk("mid_state", 8'(state), 8'd0);
        RSTn   = 1'b1;
        p_flag = 1'b0;
        step();
        step();
        chk("post_state", 8'(state), 8'd0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
